// File: rtl/trap_peak_sequencer_pkg.sv
// Shared types and widths for the trapezoid peak-capture sequencer.
package trap_pkg;

  localparam int DEFAULT_TDATA_WIDTH   = 16;
  localparam int DEFAULT_CNT_WIDTH     = 32;
  localparam int DEFAULT_HOLDOFF_WIDTH = 16;
  localparam int DELAY_WIDTH           = 14;
  localparam int THRESH_WIDTH          = 16;
  localparam int DEPTH_SUM_WIDTH       = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT,
    S_CAPTURE,
    S_HOLDOFF
  } state_t;

  // Samples from the crossing to the middle of the flat top, never less than one.
  function automatic logic [DELAY_WIDTH-1:0] wait_depth(input logic [DELAY_WIDTH-1:0] k,
                                                        input logic [DELAY_WIDTH-1:0] l);
    logic [DEPTH_SUM_WIDTH-1:0] sum;
    sum = {1'b0, k} + {1'b0, l};
    if (sum < DEPTH_SUM_WIDTH'(2))
      return DELAY_WIDTH'(1);
    else
      return sum[DEPTH_SUM_WIDTH-1:1];
  endfunction

endpackage

// File: rtl/trap_peak_sequencer_if.sv
// Minimal AXI-Stream bundle used for both the sample input and the event output.
interface trap_peak_sequencer_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/trap_peak_sequencer_sat_counter.sv
// Statistics counter that sticks at all ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/trap_peak_sequencer.sv
// Threshold-triggered peak capture for the trapezoid shaper output, with
// pile-up rejection, holdoff, a one-deep event register and statistics.
module trap_peak_sequencer
  import trap_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = DEFAULT_TDATA_WIDTH,
  parameter int CNT_WIDTH        = DEFAULT_CNT_WIDTH,
  parameter int HOLDOFF_WIDTH    = DEFAULT_HOLDOFF_WIDTH
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     enable,
  trap_peak_sequencer_if.slave     s_axis,
  input  logic [THRESH_WIDTH-1:0]  threshold,
  input  logic [DELAY_WIDTH-1:0]   Kdelay,
  input  logic [DELAY_WIDTH-1:0]   Ldelay,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff,
  trap_peak_sequencer_if.master    m_axis,
  output logic [CNT_WIDTH-1:0]     event_count,
  output logic [CNT_WIDTH-1:0]     pileup_count,
  output logic [CNT_WIDTH-1:0]     drop_count,
  output logic                     busy
);

  localparam int DW = 2 * AXIS_TDATA_WIDTH;
  localparam logic [DELAY_WIDTH-1:0]   WONE = DELAY_WIDTH'(1);
  localparam logic [HOLDOFF_WIDTH-1:0] HONE = HOLDOFF_WIDTH'(1);

  state_t                   state;
  logic                     above_q;
  logic                     above;
  logic                     crossing;
  logic                     step;
  logic                     out_free;
  logic                     event_inc;
  logic                     drop_inc;
  logic                     pileup_inc;
  logic signed [DW-1:0]     thresh_ext;
  logic [DELAY_WIDTH-1:0]   depth;
  logic [DELAY_WIDTH-1:0]   wcnt;
  logic [HOLDOFF_WIDTH-1:0] hcnt;
  logic [DW-1:0]            m_tdata;
  logic                     m_tvalid;

  assign s_axis.tready = 1'b1;
  assign m_axis.tdata  = m_tdata;
  assign m_axis.tvalid = m_tvalid;

  assign thresh_ext = {{(DW-THRESH_WIDTH){1'b0}}, threshold};
  assign above      = $signed(s_axis.tdata) > thresh_ext;
  assign crossing   = above && !above_q;
  assign step       = enable && s_axis.tvalid;
  assign out_free   = !m_tvalid || m_axis.tready;
  assign depth      = wait_depth(Kdelay, Ldelay);

  // A full output register at capture time turns the event into a drop.
  always_comb begin
    event_inc  = 1'b0;
    drop_inc   = 1'b0;
    pileup_inc = 1'b0;
    if (step) begin
      if (state == S_CAPTURE) begin
        event_inc = out_free;
        drop_inc  = !out_free;
      end
      if ((state == S_WAIT) && crossing)
        pileup_inc = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state    <= S_IDLE;
      above_q  <= 1'b0;
      wcnt     <= '0;
      hcnt     <= '0;
      busy     <= 1'b0;
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
    end else begin
      if (m_tvalid && m_axis.tready)
        m_tvalid <= 1'b0;
      if (event_inc) begin
        m_tdata  <= s_axis.tdata;
        m_tvalid <= 1'b1;
      end
      if (s_axis.tvalid)
        above_q <= above;

      if (!enable) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else if (s_axis.tvalid) begin
        case (state)
          S_IDLE: begin
            state <= S_ARMED;
            busy  <= 1'b0;
          end
          S_ARMED: begin
            if (crossing) begin
              busy <= 1'b1;
              if (depth == WONE) begin
                state <= S_CAPTURE;
              end else begin
                wcnt  <= depth - WONE;
                state <= S_WAIT;
              end
            end
          end
          // A second rising edge before the peak means overlapping pulses.
          S_WAIT: begin
            if (crossing) begin
              hcnt  <= holdoff;
              state <= S_HOLDOFF;
            end else if (wcnt <= WONE) begin
              state <= S_CAPTURE;
            end else begin
              wcnt <= wcnt - WONE;
            end
          end
          S_CAPTURE: begin
            hcnt  <= holdoff;
            state <= S_HOLDOFF;
          end
          S_HOLDOFF: begin
            if ((hcnt == '0) && !above) begin
              state <= S_ARMED;
              busy  <= 1'b0;
            end else if (hcnt != '0) begin
              hcnt <= hcnt - HONE;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_event_cnt (
    .clk   (clk),
    .clr   (areset),
    .inc   (event_inc),
    .count (event_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_pileup_cnt (
    .clk   (clk),
    .clr   (areset),
    .inc   (pileup_inc),
    .count (pileup_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk   (clk),
    .clr   (areset),
    .inc   (drop_inc),
    .count (drop_count)
  );

endmodule

// File: tb/tb_trap_peak_sequencer.sv
// Bench for trap_peak_sequencer: scenario table, corner sequences and a
// randomized run, all checked against a sample-index based reference model.
module tb_trap_peak_sequencer;
  import trap_pkg::*;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] threshold = '0;
  logic [13:0] Kdelay = '0;
  logic [13:0] Ldelay = '0;
  logic [15:0] holdoff = '0;
  logic [31:0] event_count, pileup_count, drop_count;
  logic        busy;

  logic       sc_clr = 1'b1;
  logic       sc_inc = 1'b0;
  logic [2:0] sc_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  trap_peak_sequencer_if #(.DATA_WIDTH(32)) s_if ();
  trap_peak_sequencer_if #(.DATA_WIDTH(32)) m_if ();

  trap_peak_sequencer #(
    .AXIS_TDATA_WIDTH (16),
    .CNT_WIDTH        (32),
    .HOLDOFF_WIDTH    (16)
  ) dut (
    .clk          (clk),
    .areset       (areset),
    .enable       (enable),
    .s_axis       (s_if),
    .threshold    (threshold),
    .Kdelay       (Kdelay),
    .Ldelay       (Ldelay),
    .holdoff      (holdoff),
    .m_axis       (m_if),
    .event_count  (event_count),
    .pileup_count (pileup_count),
    .drop_count   (drop_count),
    .busy         (busy)
  );

  sat_counter #(.WIDTH(3)) u_sat (
    .clk   (clk),
    .clr   (sc_clr),
    .inc   (sc_inc),
    .count (sc_cnt)
  );

  // Reference model: tracks absolute valid-sample indices rather than states.
  int cfg_thr, cfg_hold, cfg_depth;
  int md_idx, md_target, md_rearm;
  bit md_run, md_dead, md_prev, md_valid, md_busy;
  logic [31:0] md_data;
  int md_ev, md_pu, md_dr;

  typedef struct {
    string name;
    int    k, l, thr, hold;
    bit    toggle, ready;
    int    p1s, p1l, p1v, ramp;
    bit    dip;
    int    p2s, p2l, p2v;
    int    nsamp;
    int    exp_ev, exp_pu, exp_dr;
    bit    exp_valid;
    int    exp_data;
  } scen_t;

  scen_t scen[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    md_idx = 0; md_target = -1; md_rearm = 0;
    md_run = 0; md_dead = 0; md_prev = 0; md_valid = 0; md_busy = 0;
    md_data = '0; md_ev = 0; md_pu = 0; md_dr = 0;
  endtask

  task automatic model_step(input bit v, input int x, input bit en, input bit rdy);
    bit ab, cr, cap, free;
    cap  = 0;
    free = !md_valid || rdy;
    ab   = v && (x > cfg_thr);
    cr   = ab && !md_prev;
    if (!en) begin
      md_run = 0; md_target = -1; md_dead = 0;
    end else if (v) begin
      if (!md_run) begin
        md_run = 1;
      end else if (md_dead) begin
        if (md_idx >= md_rearm && !ab) md_dead = 0;
      end else if (md_target >= 0) begin
        if (md_idx < md_target && cr) begin
          md_pu++; md_target = -1; md_dead = 1; md_rearm = md_idx + cfg_hold + 1;
        end else if (md_idx == md_target) begin
          cap = 1; md_target = -1; md_dead = 1; md_rearm = md_idx + cfg_hold + 1;
        end
      end else if (cr) begin
        md_target = md_idx + cfg_depth;
      end
    end
    if (v) begin
      md_prev = ab;
      md_idx++;
    end
    if (md_valid && rdy) md_valid = 0;
    if (cap) begin
      if (free) begin
        md_valid = 1; md_data = x; md_ev++;
      end else begin
        md_dr++;
      end
    end
    md_busy = md_run && (md_target >= 0 || md_dead);
  endtask

  task automatic checkOutput();
    check("m_tvalid", m_if.tvalid, md_valid);
    check("m_tdata", m_if.tdata, md_data);
    check("event_count", event_count, md_ev);
    check("pileup_count", pileup_count, md_pu);
    check("drop_count", drop_count, md_dr);
    check("busy", busy, md_busy);
  endtask

  task automatic applyStimulus(input bit v, input int x, input bit en, input bit rdy);
    s_if.tvalid = v;
    s_if.tdata  = x;
    enable      = en;
    m_if.tready = rdy;
    model_step(v, x, en, rdy);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic set_cfg(input int k, input int l, input int thr, input int hold);
    Kdelay    = k[13:0];
    Ldelay    = l[13:0];
    threshold = thr[15:0];
    holdoff   = hold[15:0];
    cfg_thr   = thr;
    cfg_hold  = hold;
    cfg_depth = (k + l) / 2;
    if (cfg_depth < 1) cfg_depth = 1;
  endtask

  task automatic do_reset();
    areset      = 1'b1;
    enable      = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b1;
    @(posedge clk);
    #1;
    areset = 1'b0;
    model_reset();
    checkOutput();
  endtask

  task automatic feed(input int n, input int x);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, x, 1'b1, 1'b1);
  endtask

  function automatic scen_t mk_scen(input string name, input int k, input int l, input int thr,
                                    input int hold, input bit toggle, input bit ready,
                                    input int p1s, input int p1l, input int p1v, input int ramp,
                                    input bit dip, input int p2s, input int p2l, input int p2v,
                                    input int nsamp, input int ev, input int pu, input int dr,
                                    input bit valid, input int data);
    scen_t s;
    s.name = name; s.k = k; s.l = l; s.thr = thr; s.hold = hold;
    s.toggle = toggle; s.ready = ready;
    s.p1s = p1s; s.p1l = p1l; s.p1v = p1v; s.ramp = ramp; s.dip = dip;
    s.p2s = p2s; s.p2l = p2l; s.p2v = p2v; s.nsamp = nsamp;
    s.exp_ev = ev; s.exp_pu = pu; s.exp_dr = dr; s.exp_valid = valid; s.exp_data = data;
    return s;
  endfunction

  function automatic int sig_value(input scen_t s, input int i);
    int v;
    v = 0;
    if (i >= s.p1s && i < s.p1s + s.p1l) begin
      v = s.p1v + s.ramp * (i - s.p1s);
      if (s.dip && (i == s.p1s + 5 || i == s.p1s + 6)) v = 50;
    end
    if (s.p2s >= 0 && i >= s.p2s && i < s.p2s + s.p2l) v = s.p2v;
    return v;
  endfunction

  task automatic run_scenario(input scen_t s);
    int idx, cyc, x, transfers;
    bit v;
    set_cfg(s.k, s.l, s.thr, s.hold);
    do_reset();
    idx = 0;
    cyc = 0;
    while (idx < s.nsamp) begin
      v = s.toggle ? (cyc % 2 == 0) : 1'b1;
      x = v ? sig_value(s, idx) : int'($urandom_range(0, 1000));
      applyStimulus(v, x, 1'b1, s.ready);
      if (v) idx++;
      cyc++;
    end
    check({s.name, "/events"}, event_count, s.exp_ev);
    check({s.name, "/pileups"}, pileup_count, s.exp_pu);
    check({s.name, "/drops"}, drop_count, s.exp_dr);
    check({s.name, "/tvalid"}, m_if.tvalid, s.exp_valid);
    check({s.name, "/tdata"}, m_if.tdata, s.exp_data);
    if (!s.ready) begin
      transfers = 0;
      for (int i = 0; i < 8; i++) begin
        if (m_if.tvalid === 1'b1) transfers++;
        applyStimulus(1'b0, 0, 1'b1, 1'b1);
      end
      check({s.name, "/transfers"}, transfers, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit high;
    int x;

    scen[0] = mk_scen("step",        10, 20, 100,   0, 0, 1, 50, 40, 500,  0, 0,  -1,  0,   0, 120, 1, 0, 0, 0, 500);
    scen[1] = mk_scen("ramp",        10, 20, 100,   0, 0, 1, 50, 40, 200, 10, 0,  -1,  0,   0, 120, 1, 0, 0, 0, 350);
    scen[2] = mk_scen("ramp_toggle", 10, 20, 100,   0, 1, 1, 50, 40, 200, 10, 0,  -1,  0,   0, 120, 1, 0, 0, 0, 350);
    scen[3] = mk_scen("pileup",      10, 20, 100,   0, 0, 1, 50, 40, 500,  0, 1,  -1,  0,   0, 120, 0, 1, 0, 0,   0);
    scen[4] = mk_scen("ready_low",   10, 20, 100,   0, 0, 0, 50, 20, 300,  0, 0, 150, 20, 400, 250, 1, 0, 1, 1, 300);
    scen[5] = mk_scen("holdoff_60",  10, 20, 100, 100, 0, 1, 50, 20, 300,  0, 0, 110, 20, 400, 200, 1, 0, 0, 0, 300);
    scen[6] = mk_scen("holdoff_200", 10, 20, 100, 100, 0, 1, 50, 20, 300,  0, 0, 250, 20, 400, 330, 2, 0, 0, 0, 400);
    scen[7] = mk_scen("depth_one",    0,  0, 100,   0, 0, 1, 50, 40, 200, 10, 0,  -1,  0,   0, 120, 1, 0, 0, 0, 210);
    scen[8] = mk_scen("thr_equal",   10, 20, 500,   0, 0, 1, 50, 40, 500,  0, 0,  -1,  0,   0, 120, 0, 0, 0, 0,   0);

    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b1;
    model_reset();

    // Saturating counter sub-module on its own, 3 bits wide.
    @(posedge clk);
    #1;
    check("sat/clear", sc_cnt, 0);
    sc_clr = 1'b0;
    sc_inc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 6) check("sat/reach_max", sc_cnt, 7);
    end
    check("sat/no_wrap", sc_cnt, 7);
    sc_inc = 1'b0;
    sc_clr = 1'b1;
    @(posedge clk);
    #1;
    check("sat/reclear", sc_cnt, 0);

    for (int i = 0; i < 9; i++) run_scenario(scen[i]);

    // Reset while waiting for the peak, with the signal still high.
    set_cfg(10, 20, 100, 0);
    do_reset();
    feed(50, 0);
    feed(6, 500);
    check("rst_wait/busy_before", busy, 1);
    do_reset();
    check("rst_wait/tvalid", m_if.tvalid, 0);
    check("rst_wait/tdata", m_if.tdata, 0);
    check("rst_wait/events", event_count, 0);
    check("rst_wait/busy", busy, 0);
    feed(20, 500);
    check("rst_wait/no_retrigger", event_count, 0);
    feed(5, 0);
    feed(30, 500);
    check("rst_wait/recross_event", event_count, 1);
    check("rst_wait/recross_data", m_if.tdata, 500);

    // Enable dropped mid-wait while the signal stays above threshold.
    set_cfg(10, 20, 100, 0);
    do_reset();
    feed(50, 0);
    feed(5, 500);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 500, 1'b0, 1'b1);
    check("en_low/busy", busy, 0);
    check("en_low/events", event_count, 0);
    check("en_low/pileups", pileup_count, 0);
    feed(30, 500);
    check("en_low/no_trigger", event_count, 0);
    feed(5, 0);
    feed(30, 500);
    check("en_low/recross_event", event_count, 1);

    // Randomized traffic, enable glitches and backpressure against the model.
    for (int r = 0; r < 6; r++) begin
      set_cfg(int'($urandom_range(0, 20)), int'($urandom_range(0, 30)),
              int'($urandom_range(50, 150)), int'($urandom_range(0, 20)));
      do_reset();
      high = 0;
      for (int c = 0; c < 800; c++) begin
        bit v;
        v = ($urandom_range(0, 3) != 0);
        if (v && $urandom_range(0, 9) == 0) high = !high;
        x = high ? cfg_thr + 1 + int'($urandom_range(0, 300))
                 : cfg_thr - int'($urandom_range(0, 400));
        applyStimulus(v, x, ($urandom_range(0, 199) != 0), ($urandom_range(0, 2) != 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
